instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register. Decouples instruction fetch from decode in the down-sampling processor.
- Fetched instruction words are buffered in a DEPTH-entry circular FIFO. The decoder pulls the head word into an instruction register output on demand.
- Supports flush on control-flow change and flags overflow.
- All state updates on the falling edge of clk, keeping the processor's existing fetch/decode timing.

Parameters:
- IW, 10, instruction word width in bits.
- DEPTH, 4, queue entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
- clk  in  1  processor clock; all state changes on negedge.
- rst_n  in  1  synchronous active-low reset, sampled on negedge clk.
- flush  in  1  discard all queued words and invalidate the IR.
- wr_en  in  1  fetch unit presents a valid word this edge.
- wr_data  in  IW  fetched instruction word.
- ld_ir  in  1  decoder requests the next instruction into the IR.
- ir_out  out  IW  instruction register contents.
- ir_valid  out  1  ir_out holds a word loaded since the last flush/reset.
- empty  out  1  count == 0 (combinational from count).
- full  out  1  count == DEPTH (combinational from count).
- count  out  CW  number of queued words.
- ovf_err  out  1  sticky: a write was dropped because the queue was full.

Behaviour:
- Reset (rst_n=0 at negedge):
  - wr_ptr, rd_ptr, count = 0; ir_out = 0; ir_valid = 0; ovf_err = 0.
  - Therefore empty=1, full=0. Storage contents are don't-care.
  - Reset has priority over every other input, including mid-fill or mid-flush.
- Priority per edge: rst_n, then flush, then write/pop.
- Flush:
  - wr_ptr = rd_ptr = 0, count = 0, ir_valid = 0; ir_out holds its old value.
  - wr_en and ld_ir on the same edge are ignored; ovf_err is unchanged.
- Pop: ld_ir=1 and empty=0
  - ir_out <= mem[rd_ptr]; ir_valid <= 1; rd_ptr increments with natural wrap modulo DEPTH.
- ld_ir=1 with empty=1 (bypass disabled): ir_out holds; ir_valid <= 0.
- ld_ir=0: ir_out and ir_valid hold.
- Write: wr_en=1 is accepted when full=0, or when full=1 and a pop occurs on the same edge.
  - Accepted: mem[wr_ptr] <= wr_data; wr_ptr wraps modulo DEPTH.
  - Not accepted (full, no pop): word dropped, ovf_err <= 1; it stays 1 until reset.
- count update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Latency: a word written at edge N is at the head after edge N. The earliest ld_ir that loads it into ir_out is at edge N+1. Output is registered; there is no combinational path from wr_data to ir_out.
- Order is strict FIFO across pointer wrap-around.

Optional Feature:
- Macro: INSTR_PREFETCH_BYPASS_EN.
- Defined: when empty=1 and wr_en=1 and ld_ir=1 on the same edge, wr_data goes directly into ir_out and ir_valid <= 1. The queue stays empty; count and pointers are unchanged. Flush still overrides.
- Undefined: that same case stores the word in the queue (count becomes 1), ir_out holds and ir_valid <= 0.

Decomposition:
- Shared package proc_pkg:
  - INSTR_W = 10, default IW source.
  - PREFETCH_DEPTH = 4.
  - typedef logic [INSTR_W-1:0] instr_t.
- One sub-module, instr_queue_mem: DEPTH x IW register array with negedge write port (we, waddr, wdata) and combinational read port (raddr to rdata).
- Pointer, count, IR and flag logic stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wr_en=1, wr_data=0x155 -> count=0, empty=1, full=0, ir_out=0x000, ir_valid=0, ovf_err=0.
- Fill and overflow: write 0x001..0x004 -> count=4, full=1. Then write 0x3FF -> dropped, count=4, ovf_err=1 (still 1 after a later pop).
- Drain and wrap: pop 4 times -> ir_out 0x001, 0x002, 0x003, 0x004 on successive edges. Then write 0x0A0..0x0A5 interleaved with pops across pointer wrap -> output order preserved. A 5th ld_ir on empty -> ir_valid=0, ir_out holds 0x004.
- Simultaneous write and pop when full: queue 0x011..0x014, then wr_en with 0x015 plus ld_ir -> ir_out=0x011, count stays 4, ovf_err stays 0, head=0x012.
- Flush mid-stream: 3 words queued, flush=1 with wr_en=1 (0x2AA) and ld_ir=1 -> count=0, ir_valid=0, ir_out unchanged, 0x2AA not stored. Next write of 0x2AB is popped first.
- Bypass: empty queue, wr_en=1 with 0x0C3 and ld_ir=1 same edge:
  - With INSTR_PREFETCH_BYPASS_EN -> ir_out=0x0C3, ir_valid=1, count=0.
  - Without -> count=1, ir_valid=0; next ld_ir -> ir_out=0x0C3.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared processor constants and the instruction word type.
//   INSTR_W (default instruction width), PREFETCH_DEPTH (default queue depth), instr_t.
package proc_pkg;
    localparam int INSTR_W = 10;
    localparam int PREFETCH_DEPTH = 4;
    typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch/decode handshake bundle for the prefetch queue.
//   master drives flush, wr_en, wr_data, ld_ir; slave returns ir_out, ir_valid, empty, full, count, ovf_err.
interface instr_prefetch_queue_if
    import proc_pkg::*;
#(
    parameter int IW = INSTR_W,
    parameter int DEPTH = PREFETCH_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
);
    logic          flush;
    logic          wr_en;
    logic [IW-1:0] wr_data;
    logic          ld_ir;
    logic [IW-1:0] ir_out;
    logic          ir_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf_err;
    modport master (
        output flush, wr_en, wr_data, ld_ir,
        input  ir_out, ir_valid, empty, full, count, ovf_err
    );
    modport slave (
        input  flush, wr_en, wr_data, ld_ir,
        output ir_out, ir_valid, empty, full, count, ovf_err
    );
endinterface

// File: rtl/instr_queue_mem.sv
// instr_queue_mem: DEPTH x IW register array, negedge write port, combinational read port.
//   clk, we/waddr/wdata (write), raddr -> rdata (read).
module instr_queue_mem #(
    parameter int IW = 10,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [DEPTH];
    always_ff @(negedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: DEPTH-entry circular FIFO between fetch and decode feeding a registered IR.
//   clk (all updates on negedge), rst_n (sync active-low), bus (instr_prefetch_queue_if.slave).
//   Define INSTR_PREFETCH_BYPASS_EN to forward wr_data straight into the IR when the queue is empty.
module instr_prefetch_queue
    import proc_pkg::*;
#(
    parameter int IW = INSTR_W,
    parameter int DEPTH = PREFETCH_DEPTH
) (
    input logic clk,
    input logic rst_n,
    instr_prefetch_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] rdata;
    logic pop, byp, acc;
    always_comb begin
        pop = bus.ld_ir && !bus.empty;
`ifdef INSTR_PREFETCH_BYPASS_EN
        byp = bus.ld_ir && bus.empty && bus.wr_en;
`else
        byp = 1'b0;
`endif
        // a full queue still accepts when the same edge frees the head slot
        acc = bus.wr_en && (!bus.full || pop) && !byp;
    end
    assign bus.empty = bus.count == '0;
    assign bus.full  = bus.count == CW'(DEPTH);
    instr_queue_mem #(.IW(IW), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (rst_n && !bus.flush && acc),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.count    <= '0;
            bus.ir_out   <= '0;
            bus.ir_valid <= 1'b0;
            bus.ovf_err  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.count    <= '0;
            bus.ir_valid <= 1'b0;
        end else begin
            if (acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            bus.count <= bus.count + CW'(acc) - CW'(pop);
            if (bus.wr_en && bus.full && !pop) bus.ovf_err <= 1'b1;
            if (bus.ld_ir) begin
                bus.ir_out   <= pop ? rdata : (byp ? bus.wr_data : bus.ir_out);
                bus.ir_valid <= pop || byp;
            end
        end
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed vector table plus randomized run against a queue-based reference model.
module tb_instr_prefetch_queue;
    import proc_pkg::*;
    localparam int DEPTH = PREFETCH_DEPTH;
    typedef struct {
        logic   r;
        logic   f;
        logic   w;
        instr_t wd;
        logic   l;
        instr_t e_ir;
        logic   e_v;
        int     e_cnt;
        logic   e_ovf;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int tests = 0;
    int failed = 0;
    vec_t vecs[$];
    instr_t mq[$];
    instr_t m_ir;
    logic m_v, m_ovf;
`ifdef INSTR_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    always #5 clk = ~clk;
    instr_prefetch_queue_if #(.IW(INSTR_W), .DEPTH(DEPTH)) bus ();
    instr_prefetch_queue #(.IW(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    task automatic add(logic r, logic f, logic w, instr_t wd, logic l,
                       instr_t e_ir, logic e_v, int e_cnt, logic e_ovf);
        vecs.push_back('{r, f, w, wd, l, e_ir, e_v, e_cnt, e_ovf});
    endtask
    task automatic model_edge(logic r, logic f, logic w, instr_t wd, logic l);
        logic was_empty, was_full;
        if (!r) begin
            mq.delete();
            m_ir = '0;
            m_v = 1'b0;
            m_ovf = 1'b0;
        end else if (f) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            was_empty = mq.size() == 0;
            was_full = mq.size() == DEPTH;
            if (l && was_empty && w && BYP) begin
                m_ir = wd;
                m_v = 1'b1;
            end else begin
                if (l) begin
                    m_v = !was_empty;
                    if (!was_empty) m_ir = mq.pop_front();
                end
                if (w) begin
                    if (mq.size() < DEPTH) mq.push_back(wd);
                    else m_ovf = 1'b1;
                end
            end
            if (w && was_full && !(l && !was_empty)) m_ovf = 1'b1;
        end
    endtask
    task automatic apply(logic r, logic f, logic w, instr_t wd, logic l);
        rst_n = r;
        bus.flush = f;
        bus.wr_en = w;
        bus.wr_data = wd;
        bus.ld_ir = l;
        @(negedge clk);
        model_edge(r, f, w, wd, l);
        #1;
    endtask
    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_all(string tag, instr_t e_ir, logic e_v, int e_cnt, logic e_ovf);
        chk({tag, " ir_out"}, int'(bus.ir_out), int'(e_ir));
        chk({tag, " ir_valid"}, int'(bus.ir_valid), int'(e_v));
        chk({tag, " count"}, int'(bus.count), e_cnt);
        chk({tag, " empty"}, int'(bus.empty), int'(e_cnt == 0));
        chk({tag, " full"}, int'(bus.full), int'(e_cnt == DEPTH));
        chk({tag, " ovf_err"}, int'(bus.ovf_err), int'(e_ovf));
    endtask
    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.ld_ir = 1'b0;
        add(0, 0, 1, 10'h155, 0, 10'h000, 0, 0, 0);
        add(0, 0, 1, 10'h155, 0, 10'h000, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add(1, 0, 1, instr_t'(i), 0, 10'h000, 0, i, 0);
        add(1, 0, 1, 10'h3FF, 0, 10'h000, 0, 4, 1);
        for (int i = 1; i <= 4; i++) add(1, 0, 0, 10'h000, 1, instr_t'(i), 1, 4 - i, 1);
        add(1, 0, 0, 10'h000, 1, 10'h004, 0, 0, 1);
        add(1, 0, 1, 10'h0A0, 0, 10'h004, 0, 1, 1);
        add(1, 0, 1, 10'h0A1, 0, 10'h004, 0, 2, 1);
        for (int i = 0; i < 4; i++) add(1, 0, 1, instr_t'(10'h0A2 + i), 1, instr_t'(10'h0A0 + i), 1, 2, 1);
        add(1, 0, 0, 10'h000, 1, 10'h0A4, 1, 1, 1);
        add(1, 0, 0, 10'h000, 1, 10'h0A5, 1, 0, 1);
        add(0, 0, 1, 10'h155, 0, 10'h000, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add(1, 0, 1, instr_t'(10'h010 + i), 0, 10'h000, 0, i, 0);
        add(1, 0, 1, 10'h015, 1, 10'h011, 1, 4, 0);
        add(1, 0, 0, 10'h000, 1, 10'h012, 1, 3, 0);
        add(1, 1, 1, 10'h2AA, 1, 10'h012, 0, 0, 0);
        add(1, 0, 1, 10'h2AB, 0, 10'h012, 0, 1, 0);
        add(1, 0, 0, 10'h000, 1, 10'h2AB, 1, 0, 0);
`ifdef INSTR_PREFETCH_BYPASS_EN
        add(1, 0, 1, 10'h0C3, 1, 10'h0C3, 1, 0, 0);
        add(1, 0, 0, 10'h000, 1, 10'h0C3, 0, 0, 0);
`else
        add(1, 0, 1, 10'h0C3, 1, 10'h2AB, 0, 1, 0);
        add(1, 0, 0, 10'h000, 1, 10'h0C3, 1, 0, 0);
`endif
        add(1, 0, 1, 10'h111, 0, 10'h0C3, BYP ? 1'b0 : 1'b1, 1, 0);
        add(0, 1, 1, 10'h3FF, 1, 10'h000, 0, 0, 0);
        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].f, vecs[i].w, vecs[i].wd, vecs[i].l);
            check_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_v, vecs[i].e_cnt, vecs[i].e_ovf);
        end
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(9) < 6,
                  instr_t'($urandom), $urandom_range(1) == 1);
            check_all($sformatf("rnd%0d", i), m_ir, m_v, mq.size(), m_ovf);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
